// File: rtl/sma_decim_reader_pkg.sv
// Shared averager constants: FSM state codes, window-select limits and the
// helpers that turn a window select into a decimation window.
package sma_decim_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_RSVD = 2'd3
    } state_e;

    localparam int AVG_MAX_SEL = 15;
    localparam int SEL_W       = 4;
    localparam int CNT_W       = 16;
    localparam int DATA_W      = 32;

    // Last counter value of a window of 2^sel samples.
    function automatic logic [CNT_W-1:0] win_last(input logic [SEL_W-1:0] sel);
        return (16'd1 << sel) - 16'd1;
    endfunction

endpackage

// File: rtl/sma_fwft_fifo.sv
// First-word fall-through FIFO: head word is always visible on o_data.
module sma_fwft_fifo
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign o_full    = (level_r == (AW+1)'(DEPTH));
    assign o_empty   = (level_r == (AW+1)'(0));
    assign o_level   = level_r;
    assign o_data    = mem_r[rd_ptr_r];
    assign pop_ok_s  = i_pop & ~o_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_ok_s = i_push & (~o_full | pop_ok_s);

    // Storage array; cleared on reset so the head reads zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s && !i_flush) begin
            mem_r[wr_ptr_r] <= i_data;
        end
    end

    // Pointers and occupancy, wrapping naturally at the power-of-two depth.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (i_flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/sma_decim_reader.sv
// Decimating reader for the moving-average block: waits for the averager
// window to refill, then queues one averaged sample per window.
module sma_decim_reader
    import sma_decim_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_SEL    = AVG_MAX_SEL
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    input  logic                          i_update_strobe,
    input  logic [31:0]                   i_window_sel,
    input  logic [31:0]                   i_avg_data,
    output logic [31:0]                   o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_overflow,
    input  logic                          i_clr_ovf,
    output logic [1:0]                    o_state,
    output logic [$clog2(FIFO_DEPTH):0]   o_fill_level
);
    logic [SEL_W-1:0] sel_r;
    logic [SEL_W-1:0] sel_clamp_s;
    logic             stb_d1_r;
    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             sel_chg_s;
    logic             win_end_s;
    logic             push_s;
    logic             pop_s;
    logic             flush_s;
    logic             full_s;
    logic             empty_s;
    logic             drop_s;
    logic             ovf_r;

    assign sel_clamp_s = (i_window_sel > 32'(MAX_SEL)) ? SEL_W'(MAX_SEL)
                                                       : i_window_sel[SEL_W-1:0];
    assign sel_chg_s   = (sel_clamp_s != sel_r);
    assign win_end_s   = (cnt_r == win_last(sel_r));
    assign pop_s       = o_valid & i_ready;
    assign drop_s      = push_s & full_s & ~pop_s;
    assign o_valid     = ~empty_s;
    assign o_state     = state_r;
    assign o_overflow  = ovf_r;

    // Next-state, window counter and push/flush decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        push_s      = 1'b0;
        flush_s     = 1'b0;
        if (!i_enable) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
            flush_s     = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_FILL;
                    cnt_nxt_s   = '0;
                end
                ST_FILL: begin
                    if (sel_chg_s) begin
                        cnt_nxt_s = '0;
                    end else if (stb_d1_r) begin
                        if (win_end_s) begin
                            state_nxt_s = ST_RUN;
                            cnt_nxt_s   = '0;
                        end else begin
                            cnt_nxt_s = cnt_r + 16'd1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ST_RUN: begin
                    if (sel_chg_s) begin
                        state_nxt_s = ST_FILL;
                        cnt_nxt_s   = '0;
                    end else if (stb_d1_r) begin
                        if (win_end_s) begin
                            push_s    = 1'b1;
                            cnt_nxt_s = '0;
                        end else begin
                            cnt_nxt_s = cnt_r + 16'd1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end
            endcase
        end
    end

    // State, counter, select and strobe-delay registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            sel_r    <= '0;
            stb_d1_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            sel_r    <= sel_clamp_s;
            stb_d1_r <= i_update_strobe;
        end
    end

    // Sticky overflow: a new drop outranks a clear request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (i_clr_ovf) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    sma_fwft_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push_s),
        .i_pop   (pop_s),
        .i_flush (flush_s),
        .i_data  (i_avg_data),
        .o_data  (o_data),
        .o_full  (full_s),
        .o_empty (empty_s),
        .o_level (o_fill_level)
    );

endmodule

// File: tb/tb_sma_decim_reader.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// cycle by cycle against a queue-based behavioural model.
module tb_sma_decim_reader;

    localparam int FIFO_DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_update_strobe = 1'b0;
    logic [31:0] i_window_sel = 32'd0;
    logic [31:0] i_avg_data = 32'd0;
    logic        i_ready = 1'b0;
    logic        i_clr_ovf = 1'b0;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_overflow;
    logic [1:0]  o_state;
    logic [2:0]  o_fill_level;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int unsigned m_sel;
    bit          m_stb;
    int          m_phase;
    int unsigned m_cnt;
    bit          m_ovf;
    logic [31:0] m_q[$];

    sma_decim_reader #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_SEL(15)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_enable        (i_enable),
        .i_update_strobe (i_update_strobe),
        .i_window_sel    (i_window_sel),
        .i_avg_data      (i_avg_data),
        .o_data          (o_data),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_overflow      (o_overflow),
        .i_clr_ovf       (i_clr_ovf),
        .o_state         (o_state),
        .o_fill_level    (o_fill_level)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_stb = 0; m_phase = 0; m_cnt = 0; m_ovf = 0;
        m_q.delete();
    endtask

    // One clock of the reference: window of 2^sel strobes, first window refills.
    task automatic model_step();
        int unsigned cl;
        bit pop, push, drop;
        cl   = (i_window_sel > 32'd15) ? 15 : i_window_sel;
        pop  = (m_q.size() != 0) && i_ready;
        push = 0;
        if (!i_enable) begin
            m_phase = 0; m_cnt = 0; m_q.delete(); pop = 0;
        end else if (m_phase == 0) begin
            m_phase = 1; m_cnt = 0;
        end else if (cl != m_sel) begin
            m_phase = 1; m_cnt = 0;
        end else if (m_stb) begin
            m_cnt++;
            if (m_cnt == (32'd1 << m_sel)) begin
                m_cnt = 0;
                if (m_phase == 1) m_phase = 2;
                else push = 1;
            end
        end
        drop = push && (m_q.size() == FIFO_DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back(i_avg_data);
        if (drop) m_ovf = 1;
        else if (i_clr_ovf) m_ovf = 0;
        m_sel = cl;
        m_stb = i_update_strobe;
    endtask

    task automatic compare_all();
        check("state", {30'd0, o_state}, m_phase);
        check("level", {29'd0, o_fill_level}, m_q.size());
        check("valid", {31'd0, o_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
        check("ovf", {31'd0, o_overflow}, {31'd0, m_ovf});
        if (m_q.size() != 0) check("data", o_data, m_q[0]);
    endtask

    task automatic cyc();
        model_step();
        @(posedge i_clk);
        #1;
        compare_all();
    endtask

    // Strobe cycle followed by the cycle carrying the averaged data.
    task automatic strobe(input logic [31:0] d);
        i_update_strobe = 1'b1; i_avg_data = $urandom; cyc();
        i_update_strobe = 1'b0; i_avg_data = d;       cyc();
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_state", {30'd0, o_state}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_data", o_data, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Window 4: four strobes refill, then one push per four.
        i_window_sel = 32'd2; i_enable = 1'b1; cyc();
        for (int i = 0; i < 12; i++) begin
            strobe(32'd100 + 32'(i));
            if (i == 7) check("r33_first", o_data, 32'd107);
        end
        check("r33_level", {29'd0, o_fill_level}, 32'd2);
        i_ready = 1'b1; cyc(); i_ready = 1'b0;
        check("r33_second", o_data, 32'd111);

        // Window 1 with a stalled consumer overflows on the fifth push.
        i_enable = 1'b0; cyc();
        i_window_sel = 32'd0; i_enable = 1'b1; cyc();
        for (int i = 0; i < 6; i++) strobe(32'd200 + 32'(i));
        check("r34_level", {29'd0, o_fill_level}, 32'd4);
        check("r34_ovf", {31'd0, o_overflow}, 32'd1);
        i_clr_ovf = 1'b1; cyc(); i_clr_ovf = 1'b0;
        check("r34_clr", {31'd0, o_overflow}, 32'd0);

        // Full FIFO with a pop coinciding with the push.
        i_update_strobe = 1'b1; cyc();
        i_update_strobe = 1'b0; i_avg_data = 32'd555; i_ready = 1'b1; cyc();
        i_ready = 1'b0;
        check("r35_level", {29'd0, o_fill_level}, 32'd4);
        check("r35_ovf", {31'd0, o_overflow}, 32'd0);

        // Select change mid-window forces a fresh refill.
        i_enable = 1'b0; cyc();
        i_window_sel = 32'd3; i_enable = 1'b1; cyc();
        for (int i = 0; i < 13; i++) strobe(32'd300 + 32'(i));
        check("r36_run", {30'd0, o_state}, 32'd2);
        i_window_sel = 32'd1; cyc();
        check("r36_fill", {30'd0, o_state}, 32'd1);
        strobe(32'd400); strobe(32'd401);
        check("r36_run2", {30'd0, o_state}, 32'd2);
        strobe(32'd402);
        check("r36_nopush", {29'd0, o_fill_level}, 32'd0);
        strobe(32'd403);
        check("r36_push", {29'd0, o_fill_level}, 32'd1);
        check("r36_data", o_data, 32'd403);

        // Disable with three queued words flushes everything.
        for (int i = 0; i < 4; i++) strobe(32'd500 + 32'(i));
        check("r37_pre", {29'd0, o_fill_level}, 32'd3);
        i_enable = 1'b0; cyc();
        check("r37_state", {30'd0, o_state}, 32'd0);
        check("r37_valid", {31'd0, o_valid}, 32'd0);

        // Asynchronous reset mid-run, then an out-of-range select.
        i_enable = 1'b1; cyc();
        for (int i = 0; i < 6; i++) strobe(32'd600 + 32'(i));
        check("r38_pre", {29'd0, o_fill_level}, 32'd2);
        i_rst = 1'b1; #1;
        model_reset();
        check("r38_state", {30'd0, o_state}, 32'd0);
        check("r38_level", {29'd0, o_fill_level}, 32'd0);
        check("r38_valid", {31'd0, o_valid}, 32'd0);
        check("r38_data", o_data, 32'd0);
        check("r38_ovf", {31'd0, o_overflow}, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_window_sel = 32'd20; i_enable = 1'b1; cyc();
        check("r38_clamp", {28'd0, dut.sel_r}, 32'd15);
        i_window_sel = 32'd21; cyc();
        check("r38_same", {30'd0, o_state}, 32'd1);

        // Random traffic against the model.
        i_window_sel = 32'd1;
        for (int n = 0; n < 4000; n++) begin
            i_enable        = ($urandom_range(99) < 98);
            i_update_strobe = ($urandom_range(99) < 45);
            i_avg_data      = $urandom;
            i_ready         = ($urandom_range(99) < 35);
            i_clr_ovf       = ($urandom_range(99) < 4);
            if ($urandom_range(99) < 2) begin
                case ($urandom_range(5))
                    0: i_window_sel = 32'd0;
                    1: i_window_sel = 32'd1;
                    2: i_window_sel = 32'd2;
                    3: i_window_sel = 32'd3;
                    4: i_window_sel = 32'd16;
                    default: i_window_sel = 32'd1;
                endcase
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
